// File: rtl/mips_pkg.sv
// mips_pkg: shared core constants and the fetch state encoding
package mips_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic {RUN, HALT} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush (priority), load and hold
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4,
  output logic        o_valid
);
  logic [31:0] r_instr, r_pc4;
  logic        r_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_instr <= NOP;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, next-PC selection and halt FSM feeding the IF/ID register
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);
  fetch_state_t r_state, w_next_state;
  logic [31:0]  r_pc, w_next_pc, w_pc4;
  logic         w_load, w_flush;
  assign w_pc4 = r_pc + 32'd4;
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    if (r_state == HALT)
      w_flush = 1'b1;
    else if (!stall) begin
      if (pcsrc) begin
        w_next_pc = branch_target;
        w_flush   = 1'b1;
      end else if (jump) begin
        w_next_pc = jump_target;
        w_flush   = 1'b1;
      end else begin
        w_load = 1'b1;
        // the halt word is retired downstream but the PC never moves past it
        w_next_state = (imem_rdata == HALT_WORD) ? HALT : RUN;
        w_next_pc    = (imem_rdata == HALT_WORD) ? r_pc : w_pc4;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_instr (imem_rdata),
    .i_pc4   (w_pc4),
    .o_instr (if_id_instr),
    .o_pc4   (if_id_pc4),
    .o_valid (if_id_valid)
  );
  assign imem_addr = r_pc;
  assign halted    = (r_state == HALT);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tests of the fetch stage against a word memory
module tb_fetch_unit;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, pcsrc = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4;
  logic        if_id_valid, halted;
  logic [31:0] mem [0:255];
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr[9:2]];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pcsrc(pcsrc),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .halted(halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0; pcsrc = 1'b0; jump = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp %h", imem_addr, 32'h0); end
    tests++; if ({if_id_instr, if_id_pc4, if_id_valid} !== 65'h0) begin fails++; $display("FAIL reset_ifid got %h/%h/%b exp 0/0/0", if_id_instr, if_id_pc4, if_id_valid); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b exp 0", halted); end
  endtask

  task automatic test_sequential();
    restart();
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (imem_addr !== 32'(4*(i+1))) begin fails++; $display("FAIL seq_pc[%0d] got %h exp %h", i, imem_addr, 32'(4*(i+1))); end
      tests++; if ({if_id_instr, if_id_pc4, if_id_valid} !== {32'h1000_0000 + 32'(4*i), 32'(4*(i+1)), 1'b1}) begin
        fails++; $display("FAIL seq_ifid[%0d] got %h/%h/%b exp %h/%h/1", i, if_id_instr, if_id_pc4, if_id_valid, 32'h1000_0000 + 32'(4*i), 32'(4*(i+1)));
      end
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    pcsrc = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h80;
    step();
    tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL br_pc got %h exp %h", imem_addr, 32'h40); end
    tests++; if ({if_id_instr, if_id_pc4, if_id_valid} !== 65'h0) begin fails++; $display("FAIL br_bubble got %h/%h/%b exp 0/0/0", if_id_instr, if_id_pc4, if_id_valid); end
    @(negedge clk);
    pcsrc = 1'b0; jump = 1'b0;
    step();
    tests++; if ({if_id_instr, if_id_pc4, if_id_valid} !== {32'h1000_0040, 32'h44, 1'b1}) begin fails++; $display("FAIL br_target got %h/%h/%b exp 10000040/00000044/1", if_id_instr, if_id_pc4, if_id_valid); end
    tests++; if (imem_addr !== 32'h44) begin fails++; $display("FAIL br_pc2 got %h exp %h", imem_addr, 32'h44); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    stall = 1'b1; pcsrc = 1'b1; branch_target = 32'h20;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h44, 32'h1000_0040, 32'h44, 1'b1}) begin
        fails++; $display("FAIL stall_hold[%0d] got %h/%h/%h/%b exp 00000044/10000040/00000044/1", i, imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    step();
    tests++; if ({imem_addr, if_id_valid} !== {32'h20, 1'b0}) begin fails++; $display("FAIL stall_redirect got %h/%b exp 00000020/0", imem_addr, if_id_valid); end
    @(negedge clk);
    pcsrc = 1'b0;
    step();
    tests++; if ({if_id_instr, if_id_pc4, imem_addr} !== {32'h1000_0020, 32'h24, 32'h24}) begin fails++; $display("FAIL stall_resume got %h/%h/%h exp 10000020/00000024/00000024", if_id_instr, if_id_pc4, imem_addr); end
  endtask

  task automatic test_halt();
    mem[3] = 32'hFFFF_FFFF;
    restart();
    repeat (3) step();
    tests++; if ({imem_addr, halted} !== {32'h0C, 1'b0}) begin fails++; $display("FAIL pre_halt got %h/%b exp 0000000c/0", imem_addr, halted); end
    step();
    tests++; if ({if_id_instr, if_id_pc4, if_id_valid, halted, imem_addr} !== {32'hFFFF_FFFF, 32'h10, 1'b1, 1'b1, 32'h0C}) begin
      fails++; $display("FAIL halt_enter got %h/%h/%b/%b/%h exp ffffffff/00000010/1/1/0000000c", if_id_instr, if_id_pc4, if_id_valid, halted, imem_addr);
    end
    @(negedge clk);
    jump = 1'b1; jump_target = 32'h80;
    repeat (2) begin
      step();
      tests++; if ({if_id_instr, if_id_valid, halted, imem_addr} !== {32'h0, 1'b0, 1'b1, 32'h0C}) begin
        fails++; $display("FAIL halt_hold got %h/%b/%b/%h exp 0/0/1/0000000c", if_id_instr, if_id_valid, halted, imem_addr);
      end
    end
  endtask

  task automatic test_reset_in_halt();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({halted, imem_addr, if_id_instr, if_id_valid} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
      fails++; $display("FAIL async_reset got %b/%h/%h/%b exp 0/0/0/0", halted, imem_addr, if_id_instr, if_id_valid);
    end
    jump = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests++; if ({if_id_instr, if_id_pc4, if_id_valid, imem_addr} !== {32'h1000_0000, 32'h4, 1'b1, 32'h4}) begin
      fails++; $display("FAIL reset_restart got %h/%h/%b/%h exp 10000000/00000004/1/00000004", if_id_instr, if_id_pc4, if_id_valid, imem_addr);
    end
  endtask

  task automatic test_halt_redirect();
    restart();
    repeat (3) step();
    @(negedge clk);
    jump = 1'b1; jump_target = 32'h80;
    step();
    tests++; if ({halted, imem_addr, if_id_valid, if_id_instr} !== {1'b0, 32'h80, 1'b0, 32'h0}) begin
      fails++; $display("FAIL halt_flush got %b/%h/%b/%h exp 0/00000080/0/0", halted, imem_addr, if_id_valid, if_id_instr);
    end
    @(negedge clk);
    jump = 1'b0;
    step();
    tests++; if ({if_id_instr, if_id_pc4, if_id_valid, halted} !== {32'h1000_0080, 32'h84, 1'b1, 1'b0}) begin
      fails++; $display("FAIL halt_flush_next got %h/%h/%b/%b exp 10000080/00000084/1/0", if_id_instr, if_id_pc4, if_id_valid, halted);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(4*i);
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt();
    test_reset_in_halt();
    test_halt_redirect();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core. It owns the program counter and consumes the branch decision (`pcsrc`) and branch target resolved in ID by the branch unit, plus the jump redirect. On any redirect it flushes the wrong-path instruction. It honours the hazard unit's stall and stops fetching when it sees the halt word.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding that terminates fetch.

Ports:
- `clk`  in  1  Core clock; all state changes on the rising edge.
- `rst_n`  in  1  Reset. Asynchronous, active-low.
- `stall`  in  1  From the hazard unit. Holds the PC and IF/ID.
- `pcsrc`  in  1  From the branch unit. A taken branch is resolved in ID.
- `branch_target`  in  32  Branch target computed in ID.
- `jump`  in  1  A jump is decoded in ID.
- `jump_target`  in  32  Jump target computed in ID.
- `imem_addr`  out  32  Instruction memory address. Equals `pc` (combinational).
- `imem_rdata`  in  32  Instruction word. Combinational read of `imem_addr`.
- `if_id_instr`  out  32  IF/ID instruction register.
- `if_id_pc4`  out  32  IF/ID register holding PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `halted`  out  1  Fetch has stopped permanently until reset.

## Operation
- State machine states:
  - RUN: normal fetch.
  - HALT: terminal state. It is left only by reset.
- Next-PC selection in RUN, highest priority first:
  1. `stall` = 1: hold `pc`, hold IF/ID. `pcsrc` and `jump` are ignored, because the ID instruction is held and re-evaluated.
  2. `pcsrc` = 1: `pc` <= `branch_target`. IF/ID <= bubble (`instr` = 0, `pc4` = 0, `valid` = 0).
  3. `jump` = 1: `pc` <= `jump_target`. IF/ID <= bubble.
  4. Otherwise: `pc` <= `pc` + 4, wrapping mod 2^32. IF/ID <= {`imem_rdata`, `pc`+4, `valid` = 1}.
- Halt detection:
  - The fetch unit enters HALT when case 4 applies and `imem_rdata` == `HALT_WORD`.
  - The halt word is loaded into IF/ID with `valid` = 1 so downstream stages can retire it.
  - `pc` is not advanced.
- HALT behaviour:
  - `pc` is frozen.
  - From the next edge on, IF/ID holds a bubble, and all inputs are ignored.
  - `halted` = 1 from the edge that enters HALT onward.
- A halt word fetched in the same cycle as a redirect is wrong-path. The flush wins and the state stays RUN.
- `pcsrc` and `jump` both high is illegal from the decoder. `pcsrc` wins deterministically.
- Targets are used as given. No alignment checking; the low 2 bits pass through.

## Timing
- Reset (asynchronous on `rst_n` falling; takes effect without a clock):
  - `pc` = `RESET_PC`
  - `if_id_instr` = 0, `if_id_pc4` = 0, `if_id_valid` = 0
  - `halted` = 0
  - state = RUN
- Reset mid-operation, including in HALT, aborts everything immediately.
- First edge after `rst_n` rises: IF/ID captures the instruction at `RESET_PC`.
- Fetch latency: 1 cycle from `imem_addr` presentation to the word appearing on `if_id_instr`.
- Branch/jump penalty: exactly one bubble. The redirect is sampled at edge N. The target instruction is in IF/ID after edge N+1.
- `stall` held for k cycles: the PC and IF/ID are unchanged for exactly k edges, then normal progress resumes.
- `imem_addr` changes only on clock edges or asynchronous reset.

## Structure
- Shared core package (`mips_pkg`):
  - `HALT_WORD` default
  - `RESET_PC` default
  - `NOP`/bubble encoding (32'h0)
  - fetch state enum {RUN, HALT}
- Sub-modules:
  - One natural sub-module: `if_id_reg`. It holds {instr, pc4, valid} and has load/flush/hold controls with async active-low reset.
  - The next-PC mux and the FSM stay in `fetch_unit`.

## Test plan
1. Reset release with `RESET_PC` = 0 and sequential memory → `imem_addr` steps 0, 4, 8, 12. `if_id_pc4` = 4, 8, 12 with `valid` = 1.
2. `pcsrc` = 1 with `branch_target` = 0x40 while `pc` = 0x10 → next edge: `pc` = 0x40, IF/ID bubble (`valid` = 0). The following edge: `if_id_instr` = mem[0x40], `if_id_pc4` = 0x44.
3. `stall` = 1 for 3 cycles with `pcsrc` = 1 asserted throughout → `pc` and IF/ID are unchanged for 3 edges, no redirect occurs. After the stall drops with `pcsrc` still 1, the redirect happens on the next edge.
4. `HALT_WORD` at 0x0C → IF/ID gets 0xFFFFFFFF with `valid` = 1, `halted` = 1, `pc` stays 0x0C. Subsequent edges give a bubble and ignore `jump`.
5. `HALT_WORD` fetched in the same cycle `jump` = 1 to 0x80 → no halt, `halted` = 0, `pc` = 0x80, bubble.
6. `rst_n` pulsed low mid-cycle while in HALT at `pc` = 0x0C → all outputs go immediately to reset values (`halted` = 0, `pc` = `RESET_PC`) without a clock edge. Fetch restarts on the first edge after release.
